mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_pkg.sv | 52 +++++
 rtl/mc_controller_alu_decoder.sv | 44 ++++
 rtl/mc_controller.sv | 156 +++++++++++++++
 tb/tb_mc_controller.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_pkg
// Description : Shared definitions for the multicycle controller: FSM state
//               encoding, opcode values, ALU control codes, immediate-format
//               codes and ALU operation classes.
// Revision    : 1.0  initial release
// ============================================================================
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  // Opcodes
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  // ALU control codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Immediate formats
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // ALU operation classes issued by the FSM
  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

endpackage
`default_nettype wire

// File: rtl/mc_controller_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_decoder
// Description : Maps the FSM ALU operation class plus instruction fields to
//               the ALU control code.
// Ports       : i_aluop      - operation class from FSM (add / sub / funct)
//               i_funct3     - instruction bits 14:12
//               i_op5        - opcode bit 5 (1 = R-type, 0 = I-type ALU)
//               i_funct7b5   - instruction bit 30
//               o_alucontrol - ALU operation select
// Revision    : 1.0  initial release
// ============================================================================
module alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0] i_aluop,
  input  logic [2:0] i_funct3,
  input  logic       i_op5,
  input  logic       i_funct7b5,
  output logic [2:0] o_alucontrol
);

  always_comb begin
    o_alucontrol = ALU_ADD;
    case (i_aluop)
      ALUOP_ADD: o_alucontrol = ALU_ADD;
      ALUOP_SUB: o_alucontrol = ALU_SUB;
      ALUOP_FUNC: begin
        case (i_funct3)
          // Only R-type distinguishes sub via bit 30; for addi that bit is
          // part of the immediate and must be ignored.
          3'b000:  o_alucontrol = (i_op5 & i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  o_alucontrol = ALU_SLT;
          3'b110:  o_alucontrol = ALU_OR;
          3'b111:  o_alucontrol = ALU_AND;
          default: o_alucontrol = ALU_ADD;
        endcase
      end
      default: o_alucontrol = ALU_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
// Module      : mc_controller
// Description : Multicycle RISC-V style main controller: FSM sequencing
//               fetch/decode/execute, immediate-format decode and ALU decode.
// Ports       : clk, rst_n        - clock, async active-low reset
//               i_op, i_funct3, i_funct7b5 - instruction fields
//               i_zero            - ALU zero flag (branch resolve)
//               i_mem_ready       - memory access completes this cycle
//               o_immsrc, o_alusrca, o_alusrcb, o_resultsrc, o_adrsrc,
//               o_alucontrol      - datapath selects
//               o_irwrite, o_pcwrite, o_regwrite, o_memwrite - enables
//               o_state           - current FSM state (debug)
// Revision    : 1.0  initial release
// ============================================================================
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] i_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic [1:0] o_immsrc,
  output logic [1:0] o_alusrca,
  output logic [1:0] o_alusrcb,
  output logic [1:0] o_resultsrc,
  output logic       o_adrsrc,
  output logic [2:0] o_alucontrol,
  output logic       o_irwrite,
  output logic       o_pcwrite,
  output logic       o_regwrite,
  output logic       o_memwrite,
  output logic [3:0] o_state
);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] w_aluop;
  logic       w_irwrite;
  logic       w_pcwrite;
  logic       w_regwrite;
  logic       w_memwrite;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = S_FETCH;
    o_adrsrc    = 1'b0;
    o_alusrca   = 2'b00;
    o_alusrcb   = 2'b00;
    o_resultsrc = 2'b00;
    w_aluop     = ALUOP_ADD;
    w_irwrite   = 1'b0;
    w_pcwrite   = 1'b0;
    w_regwrite  = 1'b0;
    w_memwrite  = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_alusrcb   = 2'b10;
        o_resultsrc = 2'b10;
        w_irwrite   = i_mem_ready;
        w_pcwrite   = i_mem_ready;
        w_next      = i_mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        o_alusrca = 2'b01;
        o_alusrcb = 2'b01;
        case (i_op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECUTER;
          OP_IALU:      w_next = S_EXECUTEI;
          OP_BEQ:       w_next = S_BEQ;
          OP_JAL:       w_next = S_JAL;
          default:      w_next = S_FETCH;   // unknown opcode executes as NOP
        endcase
      end
      S_MEMADR: begin
        o_alusrca = 2'b10;
        o_alusrcb = 2'b01;
        w_next    = (i_op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        o_adrsrc = 1'b1;
        w_next   = i_mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        o_resultsrc = 2'b01;
        w_regwrite  = 1'b1;
      end
      S_MEMWRITE: begin
        o_adrsrc   = 1'b1;
        w_memwrite = 1'b1;
        w_next     = i_mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        o_alusrca = 2'b10;
        w_aluop   = ALUOP_FUNC;
        w_next    = S_ALUWB;
      end
      S_EXECUTEI: begin
        o_alusrca = 2'b10;
        o_alusrcb = 2'b01;
        w_aluop   = ALUOP_FUNC;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        w_regwrite = 1'b1;
      end
      S_BEQ: begin
        o_alusrca = 2'b10;
        w_aluop   = ALUOP_SUB;
        w_pcwrite = i_zero;
      end
      S_JAL: begin
        o_alusrca = 2'b01;
        o_alusrcb = 2'b10;
        w_pcwrite = 1'b1;
        w_next    = S_ALUWB;
      end
      default: w_next = S_FETCH;   // unused codes recover with no writes
    endcase
  end

  // FETCH is combinationally sensitive to mem_ready, so the enables are
  // masked directly by reset rather than relying on the state register.
  assign o_irwrite  = w_irwrite  & rst_n;
  assign o_pcwrite  = w_pcwrite  & rst_n;
  assign o_regwrite = w_regwrite & rst_n;
  assign o_memwrite = w_memwrite & rst_n;
  assign o_state    = r_state;

  always_comb begin
    case (i_op)
      OP_SW:   o_immsrc = IMM_S;
      OP_BEQ:  o_immsrc = IMM_B;
      OP_JAL:  o_immsrc = IMM_J;
      default: o_immsrc = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .i_aluop      (w_aluop),
    .i_funct3     (i_funct3),
    .i_op5        (i_op[5]),
    .i_funct7b5   (i_funct7b5),
    .o_alucontrol (o_alucontrol)
  );

endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_controller
// Description : Directed self-checking bench for mc_controller.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic [1:0] immsrc, alusrca, alusrcb, resultsrc;
  logic       adrsrc;
  logic [2:0] alucontrol;
  logic       irwrite, pcwrite, regwrite, memwrite;
  logic [3:0] state;

  int n_checks = 0;
  int n_errors = 0;

  mc_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_op         (op),
    .i_funct3     (funct3),
    .i_funct7b5   (funct7b5),
    .i_zero       (zero),
    .i_mem_ready  (mem_ready),
    .o_immsrc     (immsrc),
    .o_alusrca    (alusrca),
    .o_alusrcb    (alusrcb),
    .o_resultsrc  (resultsrc),
    .o_adrsrc     (adrsrc),
    .o_alucontrol (alucontrol),
    .o_irwrite    (irwrite),
    .o_pcwrite    (pcwrite),
    .o_regwrite   (regwrite),
    .o_memwrite   (memwrite),
    .o_state      (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; leave 1 time unit after the edge before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

  logic [3:0] lw_seq [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
  // funct3 -> expected R-type alucontrol (funct7b5 = 0)
  logic [2:0] r_f3  [4] = '{3'b110, 3'b010, 3'b111, 3'b011};
  logic [2:0] r_exp [4] = '{3'b011, 3'b101, 3'b010, 3'b000};

  initial begin
    rst_n = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
    zero = 1'b0; mem_ready = 1'b1;
    repeat (2) tick();
    chk("rst_state", {4'd0, state}, 8'd0);
    chk("rst_irwrite", {7'd0, irwrite}, 8'd0);
    chk("rst_pcwrite", {7'd0, pcwrite}, 8'd0);
    rst_n = 1'b1;

    // FETCH stalls while memory not ready
    mem_ready = 1'b0; #1;
    chk("fetch_stall_irwrite", {7'd0, irwrite}, 8'd0);
    tick();
    chk("fetch_stall_state", {4'd0, state}, 8'd0);

    // lw: 0,1,2,3,4,0
    mem_ready = 1'b1; op = LW; #1;
    chk("fetch_irwrite", {7'd0, irwrite}, 8'd1);
    chk("fetch_pcwrite", {7'd0, pcwrite}, 8'd1);
    chk("fetch_alusrcb", {6'd0, alusrcb}, 8'd2);
    chk("fetch_resultsrc", {6'd0, resultsrc}, 8'd2);
    chk("lw_immsrc", {6'd0, immsrc}, 8'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("lw_state", {4'd0, state}, {4'd0, lw_seq[i]});
      chk("lw_regwrite", {7'd0, regwrite}, (lw_seq[i] == 4'd4) ? 8'd1 : 8'd0);
    end

    // sw with 3 wait cycles in MEMWRITE
    op = SW; #1;
    chk("sw_immsrc", {6'd0, immsrc}, 8'd1);
    tick(); tick();
    chk("sw_memadr_alusrca", {6'd0, alusrca}, 8'd2);
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("sw_wait_state", {4'd0, state}, 8'd5);
      chk("sw_wait_memwrite", {7'd0, memwrite}, 8'd1);
      tick();
    end
    mem_ready = 1'b1; #1;
    chk("sw_last_memwrite", {7'd0, memwrite}, 8'd1);
    chk("sw_adrsrc", {7'd0, adrsrc}, 8'd1);
    tick();
    chk("sw_done_state", {4'd0, state}, 8'd0);

    // reset during MEMWRITE
    tick(); tick();
    mem_ready = 1'b0;
    tick();
    chk("rstmw_pre_memwrite", {7'd0, memwrite}, 8'd1);
    rst_n = 1'b0; #1;
    chk("rstmw_memwrite", {7'd0, memwrite}, 8'd0);
    chk("rstmw_state", {4'd0, state}, 8'd0);
    mem_ready = 1'b1; #1;
    chk("rstmw_irwrite", {7'd0, irwrite}, 8'd0);
    rst_n = 1'b1; #1;
    chk("post_rst_irwrite", {7'd0, irwrite}, 8'd1);

    // beq taken then not taken
    op = BQ; zero = 1'b1;
    tick(); tick();
    chk("beq1_state", {4'd0, state}, 8'd9);
    chk("beq1_pcwrite", {7'd0, pcwrite}, 8'd1);
    chk("beq_alucontrol", {5'd0, alucontrol}, 8'd1);
    chk("beq_immsrc", {6'd0, immsrc}, 8'd2);
    tick();
    chk("beq1_done", {4'd0, state}, 8'd0);
    zero = 1'b0;
    tick(); tick();
    chk("beq2_state", {4'd0, state}, 8'd9);
    chk("beq2_pcwrite", {7'd0, pcwrite}, 8'd0);
    tick();

    // jal: 0,1,10,8,0
    op = JL;
    tick(); tick();
    chk("jal_state", {4'd0, state}, 8'd10);
    chk("jal_pcwrite", {7'd0, pcwrite}, 8'd1);
    chk("jal_srcs", {4'd0, alusrca, alusrcb}, 8'b0000_0110);
    chk("jal_immsrc", {6'd0, immsrc}, 8'd3);
    tick();
    chk("jal_aluwb", {4'd0, state}, 8'd8);
    chk("jal_regwrite", {7'd0, regwrite}, 8'd1);
    tick();
    chk("jal_done", {4'd0, state}, 8'd0);

    // R-type sub, I-type addi with same fields
    op = RT; funct3 = 3'b000; funct7b5 = 1'b1;
    tick(); tick();
    chk("r_state", {4'd0, state}, 8'd6);
    chk("r_sub_alucontrol", {5'd0, alucontrol}, 8'd1);
    tick(); tick();
    chk("r_done", {4'd0, state}, 8'd0);
    op = IT;
    tick(); tick();
    chk("i_state", {4'd0, state}, 8'd7);
    chk("i_add_alucontrol", {5'd0, alucontrol}, 8'd0);
    chk("i_alusrcb", {6'd0, alusrcb}, 8'd1);
    tick(); tick();

    // R-type funct3 table
    op = RT; funct7b5 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      funct3 = r_f3[i];
      tick(); tick();
      chk("r_f3_alucontrol", {5'd0, alucontrol}, {5'd0, r_exp[i]});
      tick(); tick();
    end

    // unknown opcode is a NOP: 0,1,0
    op = 7'b1111111;
    tick();
    chk("nop_decode", {4'd0, state}, 8'd1);
    chk("nop_writes", {4'd0, irwrite, pcwrite, regwrite, memwrite}, 8'd0);
    tick();
    chk("nop_back", {4'd0, state}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
